// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: byte width, controller states, counter sizing.
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter must hold 0..w inclusive.
    function automatic int bit_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/spi_sipo_en.sv
// Enable/clear-gated serial-in parallel-out shifter, LSB first (first bit lands in bit 0).
// One cycle from en/clr to sr update; clr wins over en.
module spi_sipo_en
    import spi_pkg::*;
#(
    parameter int W = BYTE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sdi,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] sr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sdi, sr[W-1:1]};
        end
    end

endmodule

// File: rtl/spi_rx_byte_ctrl.sv
// SPI receive sequencer: oversampled sck/load/sdi, bit/byte counting, valid/ready byte output.
// Byte valid one cycle after the final sck_rise; a held byte is never overwritten, new bytes drop and set overrun.
module spi_rx_byte_ctrl #(
    parameter int BYTE_W      = spi_pkg::BYTE_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              load,
    input  logic              sdi,
    input  logic              byte_ready,
    input  logic              ovr_clr,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    output logic              overrun,
    output logic              frag_err,
    output logic              frame_active,
    output logic [CNT_W-1:0]  byte_cnt
);

    import spi_pkg::*;

    localparam int BCW    = bit_cnt_w(BYTE_W);
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BYTE_W - 1);

    logic [SYNC_STAGES-1:0] sck_sync, load_sync, sdi_sync;
    logic                   sck_prev, load_prev;
    logic [WARM_W-1:0]      warm_cnt;
    logic                   armed;
    logic                   sck_s, load_s, sdi_s;
    logic                   sck_rise, load_rise, load_fall, warm_done;

    state_t                 state, state_nxt;
    logic [BCW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                   shift_en, sr_clr, byte_done, frag_set, cnt_clr;
    logic [BYTE_W-1:0]      sr, byte_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            load_sync <= '0;
            sdi_sync  <= '0;
            sck_prev  <= 1'b0;
            load_prev <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            load_sync <= {load_sync[SYNC_STAGES-2:0], load};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            sck_prev  <= sck_s;
            load_prev <= load_s;
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign load_s    = load_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev;
    assign load_fall = ~load_s & load_prev;
    assign warm_done = (warm_cnt == WARM_W'(SYNC_STAGES));

    // After reset the synchronizers refill from zero, which would fake a load edge
    // for a frame already in progress; only arm once load has been seen low for real.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            if (!warm_done) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
            if (warm_done && !load_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign load_rise    = armed & load_s & ~load_prev;
    assign frame_active = load_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_en    = 1'b0;
        sr_clr      = 1'b0;
        byte_done   = 1'b0;
        frag_set    = 1'b0;
        cnt_clr     = 1'b0;
        case (state)
            IDLE: begin
                sr_clr      = 1'b1;
                bit_cnt_nxt = '0;
                if (load_rise) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        byte_done   = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                // A byte completing on the same cycle as the frame end is kept.
                if (load_fall) begin
                    state_nxt = IDLE;
                    if (bit_cnt_nxt != '0) begin
                        frag_set = 1'b1;
                        sr_clr   = 1'b1;
                    end
                    bit_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    spi_sipo_en #(
        .W (BYTE_W)
    ) u_sipo (
        .clk   (clk),
        .reset (reset),
        .sdi   (sdi_s),
        .en    (shift_en),
        .clr   (sr_clr),
        .sr    (sr)
    );

    assign byte_nxt = {sdi_s, sr[BYTE_W-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_data  <= '0;
            byte_valid <= 1'b0;
            overrun    <= 1'b0;
            frag_err   <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            frag_err <= frag_set;

            if (cnt_clr) begin
                byte_cnt <= '0;
            end else if (byte_done && (byte_cnt != '1)) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            if (byte_done && (!byte_valid || byte_ready)) begin
                byte_data  <= byte_nxt;
                byte_valid <= 1'b1;
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
            end

            if (byte_done && byte_valid && !byte_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_byte_ctrl.sv
// Directed bench for spi_rx_byte_ctrl: table of whole-frame vectors plus hand-written corner sequences.
module tb_spi_rx_byte_ctrl;

    logic       clk = 1'b0;
    logic       reset, sck, load, sdi, byte_ready, ovr_clr;
    logic [7:0] byte_data;
    logic       byte_valid, overrun, frag_err, frame_active;
    logic [7:0] byte_cnt;

    always #5 clk = ~clk;

    spi_rx_byte_ctrl #(
        .BYTE_W      (8),
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sck          (sck),
        .load         (load),
        .sdi          (sdi),
        .byte_ready   (byte_ready),
        .ovr_clr      (ovr_clr),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .overrun      (overrun),
        .frag_err     (frag_err),
        .frame_active (frame_active),
        .byte_cnt     (byte_cnt)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         frag_cycles = 0;
    int         rd_idx = 0;
    logic [7:0] rxq[$];

    // Record every completed transfer and every cycle frag_err is high.
    always @(negedge clk) begin
        if (!reset) begin
            if (byte_valid && byte_ready) rxq.push_back(byte_data);
            if (frag_err) frag_cycles = frag_cycles + 1;
        end
    end

    typedef struct {
        int         nb;
        logic [7:0] d0, d1, d2;
        logic       rdy;
        int         exp_n;
        logic [7:0] e0, e1, e2;
        logic [7:0] exp_cnt;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[4];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_rx(input string nm, input logic [7:0] exp);
        n_vec++;
        if (rd_idx >= rxq.size()) begin
            n_bad++;
            $display("FAIL %s: no byte received, expected %02h", nm, exp);
        end else begin
            if (rxq[rd_idx] !== exp) begin
                n_bad++;
                $display("FAIL %s: got %02h expected %02h", nm, rxq[rd_idx], exp);
            end
            rd_idx++;
        end
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        sck = 1'b0;
        tick(4);
        sck = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic frame_start;
        load = 1'b1;
        tick(6);
    endtask

    task automatic frame_end;
        sck = 1'b0;
        tick(4);
        load = 1'b0;
        tick(8);
    endtask

    initial begin
        int         f0;
        int         n0;
        logic [7:0] d[3];
        logic [7:0] e[3];
        logic [7:0] aa;

        vecs[0] = '{2, 8'hA5, 8'h3C, 8'h00, 1'b1, 2, 8'hA5, 8'h3C, 8'h00, 8'd2, 1'b0};
        vecs[1] = '{3, 8'h11, 8'h22, 8'h33, 1'b0, 1, 8'h11, 8'h00, 8'h00, 8'd3, 1'b1};
        vecs[2] = '{3, 8'h00, 8'hFF, 8'h5A, 1'b1, 3, 8'h00, 8'hFF, 8'h5A, 8'd3, 1'b0};
        vecs[3] = '{1, 8'hE7, 8'h00, 8'h00, 1'b1, 1, 8'hE7, 8'h00, 8'h00, 8'd1, 1'b0};

        reset = 1'b1; sck = 1'b0; load = 1'b0; sdi = 1'b0; byte_ready = 1'b1; ovr_clr = 1'b0;
        tick(5);
        chk("rst_byte_data", byte_data, 8'h00);
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_frag_err", frag_err, 1'b0);
        chk("rst_frame_active", frame_active, 1'b0);
        chk("rst_byte_cnt", byte_cnt, 8'd0);
        reset = 1'b0;
        tick(10);

        for (int v = 0; v < 4; v++) begin
            d = '{vecs[v].d0, vecs[v].d1, vecs[v].d2};
            e = '{vecs[v].e0, vecs[v].e1, vecs[v].e2};
            byte_ready = vecs[v].rdy;
            f0 = frag_cycles;
            frame_start;
            chk($sformatf("v%0d_frame_active", v), frame_active, 1'b1);
            for (int k = 0; k < vecs[v].nb; k++) send_byte(d[k]);
            frame_end;
            chk($sformatf("v%0d_byte_cnt", v), byte_cnt, vecs[v].exp_cnt);
            chk($sformatf("v%0d_overrun", v), overrun, vecs[v].exp_ovr);
            chk($sformatf("v%0d_frag", v), frag_cycles - f0, 0);
            if (!vecs[v].rdy) begin
                chk($sformatf("v%0d_hold_data", v), byte_data, vecs[v].e0);
                chk($sformatf("v%0d_hold_valid", v), byte_valid, 1'b1);
                ovr_clr = 1'b1;
                tick(1);
                ovr_clr = 1'b0;
                chk($sformatf("v%0d_ovr_clr", v), overrun, 1'b0);
                byte_ready = 1'b1;
                tick(3);
                chk($sformatf("v%0d_drained", v), byte_valid, 1'b0);
            end
            for (int k = 0; k < vecs[v].exp_n; k++) expect_rx($sformatf("v%0d_rx%0d", v, k), e[k]);
            chk($sformatf("v%0d_no_extra", v), rxq.size(), rd_idx);
        end

        // Frame truncated after 5 bits.
        byte_ready = 1'b1;
        f0 = frag_cycles;
        n0 = rxq.size();
        frame_start;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        frame_end;
        chk("frag_pulse_cycles", frag_cycles - f0, 1);
        chk("frag_no_byte", rxq.size(), n0);
        chk("frag_valid_low", byte_valid, 1'b0);
        frame_start;
        send_byte(8'h81);
        frame_end;
        expect_rx("frag_next_byte", 8'h81);
        chk("frag_next_no_extra", rxq.size(), rd_idx);
        chk("frag_next_cnt", byte_cnt, 8'd1);

        // Consumer accepts in the exact cycle the next byte completes.
        byte_ready = 1'b0;
        frame_start;
        send_byte(8'h55);
        chk("sim_first_data", byte_data, 8'h55);
        aa = 8'hAA;
        for (int i = 0; i < 7; i++) send_bit(aa[i]);
        sdi = aa[7];
        sck = 1'b0;
        tick(4);
        sck = 1'b1;
        tick(2);
        byte_ready = 1'b1;
        tick(3);
        frame_end;
        chk("sim_overrun", overrun, 1'b0);
        expect_rx("sim_rx0", 8'h55);
        expect_rx("sim_rx1", 8'hAA);
        chk("sim_no_extra", rxq.size(), rd_idx);

        // Reset in the middle of a byte with an unconsumed byte held.
        byte_ready = 1'b0;
        f0 = frag_cycles;
        frame_start;
        send_byte(8'hC3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("prerst_valid", byte_valid, 1'b1);
        reset = 1'b1;
        tick(1);
        chk("midrst_byte_data", byte_data, 8'h00);
        chk("midrst_byte_valid", byte_valid, 1'b0);
        chk("midrst_byte_cnt", byte_cnt, 8'd0);
        chk("midrst_frame_active", frame_active, 1'b0);
        chk("midrst_overrun", overrun, 1'b0);
        chk("midrst_frag_err", frag_err, 1'b0);
        reset = 1'b0;
        send_byte(8'hFF);
        tick(4);
        chk("stale_frame_no_byte", byte_valid, 1'b0);
        chk("stale_frame_cnt", byte_cnt, 8'd0);
        byte_ready = 1'b1;
        frame_end;
        frame_start;
        send_byte(8'h0F);
        frame_end;
        chk("postrst_frag", frag_cycles - f0, 0);
        expect_rx("postrst_rx", 8'h0F);
        chk("postrst_no_extra", rxq.size(), rd_idx);

        // 300 bytes in one frame: counter saturates.
        byte_ready = 1'b1;
        n0 = rxq.size();
        frame_start;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i));
            if (i == 9) chk("sat_cnt_10", byte_cnt, 8'd10);
        end
        frame_end;
        chk("sat_cnt_255", byte_cnt, 8'd255);
        chk("sat_rx_count", rxq.size() - n0, 300);
        for (int i = 0; i < 300; i++) expect_rx($sformatf("sat_rx%0d", i), 8'(i));
        chk("sat_overrun", overrun, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
